// File: rtl/bfm_apbslave_mem.sv
// APB3 slave memory model: word array with parameterised wait states,
// PSLVERR on out-of-range/misaligned accesses and a sticky protocol-violation flag.
//
// state | meaning
// IDLE  | waiting for a setup phase (PSEL=1, PENABLE=0)
// WAIT  | access phase, PREADY low, cnt counting down
// DONE  | access phase, PREADY high, write commits on exit
module bfm_apbslave_mem #(
    parameter int AWIDTH      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        PVIOL
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        viol_q, viol_d;

    logic [31:0] mem [0:(1<<AWIDTH)-1];

    logic              setup;
    logic              held;
    logic              addr_err;
    logic              mem_we;
    logic [AWIDTH-1:0] rd_idx;
    logic              rd_err;
    logic [31:0]       rd_word;

    assign setup    = PSEL && !PENABLE;
    assign held     = PSEL && PENABLE && (PADDR == addr_q) && (PWRITE == write_q);
    assign addr_err = (PADDR[31:AWIDTH+2] != '0) || (PADDR[1:0] != 2'b00);

    // With zero wait states DONE is entered straight from the setup phase,
    // so the read must use the live address rather than the latched one.
    assign rd_idx  = (state_q == ST_IDLE) ? PADDR[AWIDTH+1:2] : addr_q[AWIDTH+1:2];
    assign rd_err  = (state_q == ST_IDLE) ? addr_err : err_q;
    assign rd_word = rd_err ? 32'h0000_0000 : mem[rd_idx];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        viol_d  = viol_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    err_d   = addr_err;
                    cnt_d   = WS_LOAD;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_DONE;
                        if (!PWRITE) rdata_d = rd_word;
                    end
                end else if (PSEL && PENABLE) begin
                    viol_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!held) begin
                    viol_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_DONE;
                        if (!write_q) rdata_d = rd_word;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!held) viol_d = 1'b1;
                else       mem_we = write_q && !err_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0000_0000;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
            viol_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            viol_q  <= viol_d;
        end
    end

    // Array is deliberately not reset so contents survive PRESETN.
    always_ff @(posedge PCLK) begin
        if (mem_we) mem[addr_q[AWIDTH+1:2]] <= PWDATA;
    end

    assign PREADY  = (state_q == ST_DONE);
    assign PSLVERR = (state_q == ST_DONE) && err_q;
    assign PRDATA  = rdata_q;
    assign PVIOL   = viol_q;

endmodule

// File: tb/tb_bfm_apbslave_mem.sv
// Bench for bfm_apbslave_mem: three instances (0, 3, 2 wait states) on a shared APB bus,
// transaction-level model with a per-cycle compare process plus literal checks.
module tb_bfm_apbslave_mem;
    localparam int AW = 10;

    logic        PCLK;
    logic        PRESETN;
    logic [2:0]  psel;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] prdata_w [3];
    logic [2:0]  pready_w;
    logic [2:0]  pslverr_w;
    logic [2:0]  pviol_w;

    int          ws_of [3] = '{0, 3, 2};

    logic        exp_ready  [3];
    logic        exp_slverr [3];
    logic        exp_viol   [3];
    logic [31:0] exp_rdata  [3];
    logic [31:0] mem_m [int];
    int          low_cnt [3];
    logic        last_err [3];
    logic        chk_en;
    int          n_cmp;
    int          n_fail;

    bfm_apbslave_mem #(.AWIDTH(AW), .WAIT_STATES(0)) u_ws0 (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel[0]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_w[0]),
        .PREADY(pready_w[0]), .PSLVERR(pslverr_w[0]), .PVIOL(pviol_w[0]));

    bfm_apbslave_mem #(.AWIDTH(AW), .WAIT_STATES(3)) u_ws3 (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel[1]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_w[1]),
        .PREADY(pready_w[1]), .PSLVERR(pslverr_w[1]), .PVIOL(pviol_w[1]));

    bfm_apbslave_mem #(.AWIDTH(AW), .WAIT_STATES(2)) u_ws2 (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel[2]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_w[2]),
        .PREADY(pready_w[2]), .PSLVERR(pslverr_w[2]), .PVIOL(pviol_w[2]));

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge PCLK) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if ({pready_w[k], pslverr_w[k], pviol_w[k], prdata_w[k]} !==
                    {exp_ready[k], exp_slverr[k], exp_viol[k], exp_rdata[k]}) begin
                    n_fail++;
                    $display("FAIL cycle dut%0d t=%0t: rdy/err/viol/rdata got %b %b %b %h want %b %b %b %h",
                             k, $time, pready_w[k], pslverr_w[k], pviol_w[k], prdata_w[k],
                             exp_ready[k], exp_slverr[k], exp_viol[k], exp_rdata[k]);
                end
                if (psel[k] && PENABLE && !pready_w[k]) low_cnt[k]++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
        return ((a >> (AW + 2)) != 0) || (a[1:0] != 2'b00);
    endfunction

    function automatic int key(input int k, input logic [31:0] a);
        return (k << 16) | int'(a[AW+1:2]);
    endfunction

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            exp_ready[k]  = 1'b0;
            exp_slverr[k] = 1'b0;
            exp_viol[k]   = 1'b0;
            exp_rdata[k]  = 32'h0;
        end
    endtask

    task automatic expect_done(input int k, input logic wr, input logic err, input logic [31:0] addr);
        exp_ready[k]  = 1'b1;
        exp_slverr[k] = err;
        if (!wr) exp_rdata[k] = err ? 32'h0 : mem_m[key(k, addr)];
        last_err[k] = pslverr_w[k] & pready_w[k];
    endtask

    // abort_at: access cycle (1-based) in which PSEL is dropped, 0 for a clean transfer
    task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int abort_at);
        logic err;
        int   ws;
        ws  = ws_of[k];
        err = addr_bad(addr);
        low_cnt[k]  = 0;
        last_err[k] = 1'b0;
        psel[k] = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        step();
        PENABLE = 1'b1;
        if (ws == 0) expect_done(k, wr, err, addr);
        for (int c = 1; c <= ws + 1; c++) begin
            if (c == abort_at) psel[k] = 1'b0;
            step();
            if (c == abort_at) begin
                exp_viol[k] = 1'b1;
                break;
            end
            if (c == ws + 1) begin
                if (wr && !err) mem_m[key(k, addr)] = wd;
                exp_ready[k]  = 1'b0;
                exp_slverr[k] = 1'b0;
            end else if (c == ws) begin
                expect_done(k, wr, err, addr);
            end
        end
        psel[k] = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; chk_en = 1'b0;
        PRESETN = 1'b0; psel = 3'b000; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'h0; PWDATA = 32'h0;
        for (int k = 0; k < 3; k++) begin
            low_cnt[k] = 0;
            last_err[k] = 1'b0;
        end
        model_reset();
        repeat (2) @(posedge PCLK);
        #1 PRESETN = 1'b1;
        chk_en = 1'b1;
        check("rst_prdata", prdata_w[1], 32'h0);
        check("rst_flags", {29'b0, pready_w | pslverr_w | pviol_w}, 32'h0);

        // zero wait states, back-to-back transfers
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        xfer(0, 1'b0, 32'h10, 32'h0, 0);
        check("ws0_rd_0x10", prdata_w[0], 32'hDEADBEEF);
        check("ws0_rd_err", {31'b0, last_err[0]}, 32'h0);
        xfer(0, 1'b1, 32'h0, 32'h11112222, 0);

        // out of range
        xfer(0, 1'b1, 32'h1000, 32'h1234, 0);
        check("oor_wr_slverr", {31'b0, last_err[0]}, 32'h1);
        xfer(0, 1'b0, 32'h1000, 32'h0, 0);
        check("oor_rd_slverr", {31'b0, last_err[0]}, 32'h1);
        check("oor_rd_data", prdata_w[0], 32'h0);
        xfer(0, 1'b0, 32'h0, 32'h0, 0);
        check("rd_0x0_after_oor", prdata_w[0], 32'h11112222);

        // misaligned
        xfer(0, 1'b1, 32'h2, 32'h99999999, 0);
        check("mis_wr_slverr", {31'b0, last_err[0]}, 32'h1);
        xfer(0, 1'b0, 32'h6, 32'h0, 0);
        check("mis_rd_slverr", {31'b0, last_err[0]}, 32'h1);
        xfer(0, 1'b0, 32'h0, 32'h0, 0);
        check("rd_0x0_after_mis", prdata_w[0], 32'h11112222);

        // three wait states
        xfer(1, 1'b1, 32'h3FC, 32'h5A5A0001, 0);
        check("ws3_wr_low_cycles", low_cnt[1], 32'd3);
        xfer(1, 1'b0, 32'h3FC, 32'h0, 0);
        check("ws3_rd_low_cycles", low_cnt[1], 32'd3);
        check("ws3_rd_data", prdata_w[1], 32'h5A5A0001);

        // two wait states: abort by dropping PSEL in first wait cycle
        xfer(2, 1'b1, 32'h20, 32'h0C0FFEE0, 0);
        xfer(2, 1'b1, 32'h40, 32'h0BADF00D, 0);
        xfer(2, 1'b1, 32'h20, 32'hFFFF0000, 1);
        check("viol_set", {31'b0, pviol_w[2]}, 32'h1);
        repeat (3) step();
        check("viol_sticky", {31'b0, pviol_w[2]}, 32'h1);
        xfer(2, 1'b0, 32'h20, 32'h0, 0);
        check("abort_no_write", prdata_w[2], 32'h0C0FFEE0);
        xfer(2, 1'b1, 32'h24, 32'h00000007, 0);
        xfer(2, 1'b0, 32'h24, 32'h0, 0);
        check("post_viol_xfer", prdata_w[2], 32'h00000007);

        // reset in the middle of a write
        psel[2] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h40; PWDATA = 32'hBAD0BAD0;
        step();
        PENABLE = 1'b1;
        #2 PRESETN = 1'b0;
        model_reset();
        psel = 3'b000; PENABLE = 1'b0;
        #1;
        check("mid_rst_pready", {31'b0, pready_w[2]}, 32'h0);
        check("mid_rst_pslverr", {31'b0, pslverr_w[2]}, 32'h0);
        check("mid_rst_pviol", {31'b0, pviol_w[2]}, 32'h0);
        check("mid_rst_prdata", prdata_w[2], 32'h0);
        step();
        step();
        PRESETN = 1'b1;
        step();
        xfer(2, 1'b0, 32'h40, 32'h0, 0);
        check("rst_retains_mem", prdata_w[2], 32'h0BADF00D);

        // PENABLE with PSEL while idle
        psel[0] = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h10;
        step();
        exp_viol[0] = 1'b1;
        psel[0] = 1'b0; PENABLE = 1'b0;
        check("idle_penable_viol", {31'b0, pviol_w[0]}, 32'h1);
        xfer(0, 1'b0, 32'h10, 32'h0, 0);
        check("after_idle_viol_rd", prdata_w[0], 32'hDEADBEEF);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
